seg7_to_bcd_capture: RTL and testbench
======================================

// Module: seg7_to_bcd_capture
// PURPOSE
//  Decodes a stream of 7-segment patterns {a,b,c,d,e,f,g} (a = MSB) back to BCD digits.
//  Groups DIGITS consecutive patterns into one packed BCD word and flags unrecognised glyphs.
//  Sits on the display-readback/loopback path, inverse of the BCD->7-segment encoder.
//  Valid/ready on both sides.
// PARAMETERS
//  DIGITS          4   digits per frame, >=1; output word is 4*DIGITS bits
//  SEG_ACTIVE_LOW  0   1: seg input is inverted before decode (common-anode displays)
// PORTS
//  clk        in   1          clock, single domain
//  rst_n      in   1          asynchronous reset, active-low
//  seg_valid  in   1          seg beat valid
//  seg_ready  out  1          block accepts a seg beat
//  seg        in   7          {a,b,c,d,e,f,g} pattern
//  sync_clr   in   1          discard partial frame, restart at digit 0
//  bcd_valid  out  1          completed frame on bcd/err outputs
//  bcd_ready  in   1          downstream accepts frame
//  bcd        out  4*DIGITS   first-received digit in MS nibble, last in nibble 0
//  err_mask   out  DIGITS     bit i set = nibble i was an unrecognised glyph
//  err        out  1          OR of err_mask
// BEHAVIOUR
//  Decode table (after optional inversion):
//   0=1111110  1=0110000  2=1101101  3=1111001  4=0110011
//   5=1011011  6=1011111  7=1110000  8=1111111  9=1111011
//   Any other pattern, incl. blank 0000000 -> nibble 4'hF, err bit set.
//  FSM, 2 states:
//   COLLECT: seg_ready=1.
//    On seg_valid&seg_ready: accumulator <= {acc[4*DIGITS-5:0], digit}; err shift likewise; idx++.
//    Beat with idx==DIGITS-1 -> HOLD; idx<=0.
//   HOLD: seg_ready=0, bcd_valid=1, bcd/err_mask/err stable.
//    On bcd_ready -> COLLECT; next beat accepted the following cycle.
//  Latency: bcd_valid rises the cycle after the last digit is accepted.
//  Max throughput: one frame per DIGITS+1 cycles.
//  bcd, err_mask, err registered; held after handshake until the next frame completes.
//  sync_clr in COLLECT: idx<=0, partial accumulator/err bits cleared.
//   Has priority over a same-cycle seg beat; that beat is dropped, with seg_ready still 1 (counts as consumed).
//  sync_clr in HOLD: ignored; the completed frame is preserved.
//  idx counter width max(1,$clog2(DIGITS)); DIGITS==1 -> every beat completes a frame.
//  Reset (async, rst_n=0):
//   state=COLLECT, idx=0, seg_ready=1, bcd_valid=0, bcd=0, err_mask=0, err=0.
//   Reset mid-frame or in HOLD discards all data.
// CONFIGURATION
//  SEG7_ALT_GLYPHS_EN defined: additionally accept alternate glyphs, decoded with no error:
//   6=0011111 (no a), 7=1110010 (with f), 9=1110011 (no d).
//  Not defined: these three patterns -> 4'hF with err bit set.
// TESTING
//  DIGITS=4, beats 0110000,1101101,1111001,0110011 -> bcd=16'h1234, err_mask=0, err=0.
//   bcd_valid rises 1 cycle after 4th beat.
//  Beats "1", 0000001, "3", "4" -> bcd=16'h1F34, err_mask=4'b0100, err=1.
//  Frame complete, bcd_ready=0 for 5 cycles, seg_valid=1:
//   seg_ready=0, bcd unchanged; bcd_ready=1 -> COLLECT next cycle.
//  2 beats, sync_clr pulse (with a beat), then 9,8,7,6 -> bcd=16'h9876, err=0.
//  Beat 0011111 x4:
//   with SEG7_ALT_GLYPHS_EN -> 16'h6666, err=0;
//   without -> 16'hFFFF, err_mask=4'hF.
//  SEG_ACTIVE_LOW=1, beat 0000001 x4 -> 16'h0000, err=0.
//  rst_n low after 3 beats, then 4 fresh beats -> only fresh digits appear.

Source files
------------

// File: rtl/seg7_to_bcd_capture.sv
// Decodes a stream of 7-segment glyphs back into a packed BCD frame of DIGITS nibbles.
// Build option: define SEG7_ALT_GLYPHS_EN to also accept the alternate 6/7/9 glyphs.
module seg7_to_bcd_capture #(
  parameter int DIGITS         = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                seg_valid,
  output logic                seg_ready,
  input  logic [6:0]          seg,
  input  logic                sync_clr,
  output logic                bcd_valid,
  input  logic                bcd_ready,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   err_mask,
  output logic                err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [BCD_W-1:0]   acc, acc_nxt;
  logic [DIGITS-1:0]  acc_err, acc_err_nxt;
  logic [6:0]         seg_dec;
  logic [3:0]         digit;
  logic               digit_err;
  logic               beat, last_beat;

  // Returns {err, nibble}; unknown glyphs map to 4'hF with the error bit set.
  function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b1111110: res = 5'h00;
      7'b0110000: res = 5'h01;
      7'b1101101: res = 5'h02;
      7'b1111001: res = 5'h03;
      7'b0110011: res = 5'h04;
      7'b1011011: res = 5'h05;
      7'b1011111: res = 5'h06;
      7'b1110000: res = 5'h07;
      7'b1111111: res = 5'h08;
      7'b1111011: res = 5'h09;
`ifdef SEG7_ALT_GLYPHS_EN
      7'b0011111: res = 5'h06;
      7'b1110010: res = 5'h07;
      7'b1110011: res = 5'h09;
`endif
      default:    res = 5'h1F;
    endcase
    return res;
  endfunction

  assign seg_dec                = SEG_ACTIVE_LOW ? ~seg : seg;
  assign {digit_err, digit}     = decode_glyph(seg_dec);
  // A same-cycle sync_clr swallows the beat even though seg_ready is high.
  assign beat      = seg_valid && seg_ready && !sync_clr;
  assign last_beat = beat && (idx == LAST_IDX);

  generate
    if (DIGITS == 1) begin : g_single
      assign acc_nxt     = digit;
      assign acc_err_nxt = digit_err;
    end else begin : g_multi
      assign acc_nxt     = {acc[BCD_W-5:0], digit};
      assign acc_err_nxt = {acc_err[DIGITS-2:0], digit_err};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (last_beat) state_nxt = HOLD;
      HOLD:    if (bcd_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    seg_ready = (state == COLLECT);
    bcd_valid = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      acc      <= '0;
      acc_err  <= '0;
      bcd      <= '0;
      err_mask <= '0;
      err      <= 1'b0;
    end else if (state == COLLECT) begin
      if (sync_clr) begin
        idx     <= '0;
        acc     <= '0;
        acc_err <= '0;
      end else if (last_beat) begin
        idx      <= '0;
        acc      <= '0;
        acc_err  <= '0;
        bcd      <= acc_nxt;
        err_mask <= acc_err_nxt;
        err      <= |acc_err_nxt;
      end else if (beat) begin
        idx     <= idx + IDX_W'(1);
        acc     <= acc_nxt;
        acc_err <= acc_err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg7_to_bcd_capture.sv
// Directed bench for seg7_to_bcd_capture: DIGITS=4 active-high instance plus an active-low instance.
module tb_seg7_to_bcd_capture;

  localparam logic [6:0] G0 = 7'b1111110, G1 = 7'b0110000, G2 = 7'b1101101,
                         G3 = 7'b1111001, G4 = 7'b0110011, G5 = 7'b1011011,
                         G6 = 7'b1011111, G7 = 7'b1110000, G8 = 7'b1111111,
                         G9 = 7'b1111011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seg_valid, seg_ready, sync_clr, bcd_valid, bcd_ready, err;
  logic [6:0]  seg;
  logic [15:0] bcd;
  logic [3:0]  err_mask;

  logic        al_seg_valid, al_seg_ready, al_sync_clr, al_bcd_valid, al_bcd_ready, al_err;
  logic [6:0]  al_seg;
  logic [15:0] al_bcd;
  logic [3:0]  al_err_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_to_bcd_capture #(.DIGITS(4), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .seg_valid(seg_valid), .seg_ready(seg_ready), .seg(seg),
    .sync_clr(sync_clr), .bcd_valid(bcd_valid), .bcd_ready(bcd_ready), .bcd(bcd),
    .err_mask(err_mask), .err(err)
  );

  seg7_to_bcd_capture #(.DIGITS(4), .SEG_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .seg_valid(al_seg_valid), .seg_ready(al_seg_ready), .seg(al_seg),
    .sync_clr(al_sync_clr), .bcd_valid(al_bcd_valid), .bcd_ready(al_bcd_ready), .bcd(al_bcd),
    .err_mask(al_err_mask), .err(al_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] p);
    seg       = p;
    seg_valid = 1'b1;
    tick();
    seg_valid = 1'b0;
  endtask

  task automatic accept();
    bcd_ready = 1'b1;
    tick();
    bcd_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; seg_valid = 1'b0; seg = '0; sync_clr = 1'b0; bcd_ready = 1'b0;
    al_seg_valid = 1'b0; al_seg = '0; al_sync_clr = 1'b0; al_bcd_ready = 1'b0;
    tick(); tick();
    check("rst_seg_ready", 32'(seg_ready), 32'd1);
    check("rst_bcd_valid", 32'(bcd_valid), 32'd0);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_err_mask", 32'(err_mask), 32'h0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Frame 1234, valid only after the fourth beat
    send(G1); send(G2); send(G3);
    check("f1_not_yet", 32'(bcd_valid), 32'd0);
    send(G4);
    check("f1_valid", 32'(bcd_valid), 32'd1);
    check("f1_bcd", 32'(bcd), 32'h1234);
    check("f1_mask", 32'(err_mask), 32'h0);
    check("f1_err", 32'(err), 32'd0);
    check("f1_hold_ready", 32'(seg_ready), 32'd0);
    accept();
    check("f1_back_ready", 32'(seg_ready), 32'd1);
    check("f1_valid_drop", 32'(bcd_valid), 32'd0);
    check("f1_bcd_held", 32'(bcd), 32'h1234);

    // Frame with a bad glyph in the second position
    send(G1); send(7'b0000001); send(G3); send(G4);
    check("f2_bcd", 32'(bcd), 32'h1F34);
    check("f2_mask", 32'(err_mask), 32'h4);
    check("f2_err", 32'(err), 32'd1);

    // Backpressure in HOLD; sync_clr there must not disturb the frame
    seg_valid = 1'b1; seg = G8; sync_clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_seg_ready", 32'(seg_ready), 32'd0);
      check("bp_bcd", 32'(bcd), 32'h1F34);
      check("bp_valid", 32'(bcd_valid), 32'd1);
    end
    seg_valid = 1'b0; sync_clr = 1'b0;
    accept();
    check("bp_release", 32'(seg_ready), 32'd1);

    // Partial frame, then sync_clr together with a beat that gets dropped
    send(G5); send(G5);
    seg = G1; seg_valid = 1'b1; sync_clr = 1'b1;
    tick();
    seg_valid = 1'b0; sync_clr = 1'b0;
    check("clr_ready", 32'(seg_ready), 32'd1);
    send(G9); send(G8); send(G7);
    check("clr_not_yet", 32'(bcd_valid), 32'd0);
    send(G6);
    check("clr_valid", 32'(bcd_valid), 32'd1);
    check("clr_bcd", 32'(bcd), 32'h9876);
    check("clr_err", 32'(err), 32'd0);
    accept();

    // Alternate glyph for 6
    for (int i = 0; i < 4; i++) send(7'b0011111);
`ifdef SEG7_ALT_GLYPHS_EN
    check("alt_bcd", 32'(bcd), 32'h6666);
    check("alt_err", 32'(err), 32'd0);
`else
    check("alt_bcd", 32'(bcd), 32'hFFFF);
    check("alt_mask", 32'(err_mask), 32'hF);
    check("alt_err", 32'(err), 32'd1);
`endif
    accept();

    // Active-low instance: inverted 0000001 is the glyph for 0
    al_seg = 7'b0000001;
    al_seg_valid = 1'b1;
    repeat (4) tick();
    al_seg_valid = 1'b0;
    check("al_valid", 32'(al_bcd_valid), 32'd1);
    check("al_bcd", 32'(al_bcd), 32'h0000);
    check("al_err", 32'(al_err), 32'd0);

    // Reset mid-frame discards the partial digits
    send(G1); send(G2); send(G3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bcd_valid), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    send(G5); send(G6); send(G7);
    check("fresh_not_yet", 32'(bcd_valid), 32'd0);
    send(G8);
    check("fresh_valid", 32'(bcd_valid), 32'd1);
    check("fresh_bcd", 32'(bcd), 32'h5678);
    check("fresh_err", 32'(err), 32'd0);
    accept();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
